// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the 4-entry register bank.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: default data width, 2-bit register address type, clear-sequencer
// state enum.
package reg_bank_pkg;

  localparam int WIDTH_DEF = 8;

  // Register select: 0=A, 1=B, 2=C, 3=D.
  typedef logic [1:0] reg_addr_t;

  // The state value is used directly as the busy flag, so CLEAR must be 1.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_bank_4x8_if.sv
// Bus bundle between a register-bank controller and the register bank.
// Latency: n/a (wires only).
// Backpressure: busy tells the master that requests are being ignored.
//
// Signals: wr_en/wr_addr/wr_data write port, inc_en/inc_addr increment port,
// clr_req clear start, busy/carry status, out_a..out_d register contents.
interface reg_bank_4x8_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             wr_en;
  reg_addr_t        wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             inc_en;
  reg_addr_t        inc_addr;
  logic             clr_req;
  logic             busy;
  logic             carry;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;

  modport master (
    output wr_en, wr_addr, wr_data, inc_en, inc_addr, clr_req,
    input  busy, carry, out_a, out_b, out_c, out_d
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, inc_en, inc_addr, clr_req,
    output busy, carry, out_a, out_b, out_c, out_d
  );

endinterface

// File: rtl/reg_bank_clear_fsm.sv
// Sequencer that walks a clear strobe across the four registers.
// Latency: busy rises one edge after clr_req, stays high for exactly 4 cycles.
// Backpressure: clr_req is ignored while the sequence is running.
//
// Ports: clk, rst_n (async active-low), i_clr_req start request,
//        o_busy sequence active, o_clr_idx register to clear, o_clr_stb clear now.
module reg_bank_clear_fsm
  import reg_bank_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_clr_req,
  output logic      o_busy,
  output reg_addr_t o_clr_idx,
  output logic      o_clr_stb
);

  clr_state_t r_state;
  clr_state_t w_state_nxt;
  reg_addr_t  r_idx;
  reg_addr_t  w_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = '0;
        end
      end
      CLEAR: begin
        // Index wraps 3 -> 0 on the last clear edge, ready for the next run.
        w_idx_nxt = reg_addr_t'(r_idx + 2'd1);
        if (r_idx == 2'd3) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Both outputs are the state flop itself, so they stay glitch-free.
  assign o_busy    = (r_state == CLEAR);
  assign o_clr_stb = (r_state == CLEAR);
  assign o_clr_idx = r_idx;

endmodule

// File: rtl/reg_bank_4x8.sv
// Four WIDTH-bit registers with write, increment-with-carry and sequential clear.
// Latency: write/increment visible 1 cycle later (0 with REG_BANK_BYPASS_EN write-through).
// Backpressure: while busy (or in the clr_req cycle) wr_en/inc_en/clr_req are dropped.
//
// Ports: clk, rst_n (async active-low), bus (reg_bank_4x8_if.slave).
// Build option: define REG_BANK_BYPASS_EN to forward wr_data onto the
// addressed output in the same cycle as an accepted write.
module reg_bank_4x8
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
  input  logic           clk,
  input  logic           rst_n,
  reg_bank_4x8_if.slave  bus
);

  logic [WIDTH-1:0] r_regs [4];
  logic             r_carry;

  logic             w_busy;
  reg_addr_t        w_clr_idx;
  logic             w_clr_stb;
  logic             w_wr_go;
  logic             w_inc_go;
  logic [WIDTH-1:0] w_out [4];

  reg_bank_clear_fsm u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr_req (bus.clr_req),
    .o_busy    (w_busy),
    .o_clr_idx (w_clr_idx),
    .o_clr_stb (w_clr_stb)
  );

  // A clr_req in IDLE wins over any write/increment presented alongside it.
  assign w_wr_go  = bus.wr_en && !w_busy && !bus.clr_req;
  // Write has priority when both target the same register; carry then holds.
  assign w_inc_go = bus.inc_en && !w_busy && !bus.clr_req &&
                    !(bus.wr_en && (bus.wr_addr == bus.inc_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_clr_stb) begin
      r_regs[w_clr_idx] <= RESET_VAL;
    end else begin
      if (w_wr_go) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      if (w_inc_go) begin
        r_regs[bus.inc_addr] <= r_regs[bus.inc_addr] + WIDTH'(1);
      end
    end
  end

  // Carry-out is set only when the incremented value was all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_inc_go) begin
      r_carry <= (r_regs[bus.inc_addr] == {WIDTH{1'b1}});
    end
  end

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_out[i] = r_regs[i];
      if (w_wr_go && (bus.wr_addr == reg_addr_t'(i))) begin
        w_out[i] = bus.wr_data;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_out[i] = r_regs[i];
    end
  end
`endif

  assign bus.out_a = w_out[0];
  assign bus.out_b = w_out[1];
  assign bus.out_c = w_out[2];
  assign bus.out_d = w_out[3];
  assign bus.busy  = w_busy;
  assign bus.carry = r_carry;

endmodule

// File: tb/tb_reg_bank_4x8.sv
// Self-checking bench for reg_bank_4x8: directed scenarios then random traffic.
// Latency: checks outputs 1 time unit after each rising edge and after each input change.
// Backpressure: the model drops requests while a clear is pending or running.
module tb_reg_bank_4x8;
  import reg_bank_pkg::*;

  localparam logic [7:0] RV = 8'h00;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  // Reference state: register contents, carry and the number of clear
  // edges still to come (the clear walks A, B, C, D in order).
  logic [7:0] m_reg [4];
  logic       m_carry;
  int         m_clr_left;

  reg_bank_4x8_if #(.WIDTH(8)) bus ();

  reg_bank_4x8 #(.WIDTH(8), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic accepting();
    return (m_clr_left == 0) && !bus.clr_req;
  endfunction

  function automatic logic [7:0] exp_out(input int x);
`ifdef REG_BANK_BYPASS_EN
    if (accepting() && bus.wr_en && (int'(bus.wr_addr) == x)) return bus.wr_data;
`endif
    return m_reg[x];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = RV;
    m_carry    = 1'b0;
    m_clr_left = 0;
  endtask

  // Apply one rising edge's worth of behaviour to the model.
  task automatic model_edge();
    logic [7:0] old;
    if (!rst_n) begin
      model_reset();
    end else if (m_clr_left > 0) begin
      m_reg[4 - m_clr_left] = RV;
      m_clr_left--;
    end else if (bus.clr_req) begin
      m_clr_left = 4;
    end else begin
      old = m_reg[bus.inc_addr];
      if (bus.wr_en) m_reg[bus.wr_addr] = bus.wr_data;
      if (bus.inc_en && !(bus.wr_en && bus.wr_addr == bus.inc_addr)) begin
        m_carry = (old == 8'hFF);
        m_reg[bus.inc_addr] = 8'((int'(old) + 1) % 256);
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".a"}, 32'(bus.out_a), 32'(exp_out(0)));
    check({tag, ".b"}, 32'(bus.out_b), 32'(exp_out(1)));
    check({tag, ".c"}, 32'(bus.out_c), 32'(exp_out(2)));
    check({tag, ".d"}, 32'(bus.out_d), 32'(exp_out(3)));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_clr_left != 0));
    check({tag, ".carry"}, 32'(bus.carry), 32'(m_carry));
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input logic [7:0] wd,
                       input logic ie, input reg_addr_t ia, input logic cr,
                       input string tag);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.inc_en  = ie;
    bus.inc_addr = ia;
    bus.clr_req = cr;
    #1;
    cmp_all({tag, ".comb"});
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cmp_all(tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, tag);
  endtask

  task automatic wr(input reg_addr_t a, input logic [7:0] d, input string tag);
    drive(1'b1, a, d, 1'b0, 2'd0, 1'b0, tag);
    cyc(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    model_reset();
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.inc_en = 1'b0; bus.inc_addr = '0; bus.clr_req = 1'b0;
    #2;
    cmp_all("reset");
    #10;
    rst_n = 1'b1;

    // Basic writes with 1-cycle latency.
    wr(2'd0, 8'h00, "wr_a");
    wr(2'd1, 8'hF0, "wr_b");
    wr(2'd2, 8'h0F, "wr_c");
    wr(2'd3, 8'hFF, "wr_d");

    // Increment wrap with carry, then normal increment clears carry.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, "inc_wrap"); cyc("inc_wrap");
    check("inc_wrap.out_d", 32'(bus.out_d), 32'h00);
    check("inc_wrap.carry", 32'(bus.carry), 32'h1);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, "inc_one"); cyc("inc_one");
    check("inc_one.out_d", 32'(bus.out_d), 32'h01);
    check("inc_one.carry", 32'(bus.carry), 32'h0);

    // Write+inc collision on the same address, then on different addresses.
    drive(1'b1, 2'd1, 8'h55, 1'b1, 2'd1, 1'b0, "coll_same"); cyc("coll_same");
    check("coll_same.out_b", 32'(bus.out_b), 32'h55);
    drive(1'b1, 2'd1, 8'h55, 1'b1, 2'd2, 1'b0, "coll_diff"); cyc("coll_diff");
    check("coll_diff.out_c", 32'(bus.out_c), 32'h10);

    // Sequential clear from AA with a write attempted during busy.
    for (int i = 0; i < 4; i++) wr(reg_addr_t'(i), 8'hAA, "fill");
    drive(1'b1, 2'd0, 8'h11, 1'b1, 2'd1, 1'b1, "clr_req"); cyc("clr_start");
    for (int i = 0; i < 4; i++) begin
      check("clr.busy_seen", 32'(bus.busy), 32'h1);
      drive(1'b1, reg_addr_t'(i), 8'h77, 1'b1, reg_addr_t'(i), 1'b1, "clr_busy_wr");
      cyc("clr_step");
    end
    check("clr.done_busy", 32'(bus.busy), 32'h0);
    check("clr.done_d", 32'(bus.out_d), 32'h00);
    idle("post_clr"); cyc("post_clr");

    // Reset in the middle of a clear; the clear must not resume.
    for (int i = 0; i < 4; i++) wr(reg_addr_t'(i), 8'hAA, "fill2");
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, "clr2_req"); cyc("clr2_start");
    idle("clr2"); cyc("clr2_c0"); cyc("clr2_c1");
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all("rst_mid");
    check("rst_mid.busy", 32'(bus.busy), 32'h0);
    check("rst_mid.out_d", 32'(bus.out_d), 32'h00);
    cyc("rst_hold");
    #2;
    rst_n = 1'b1;
    cyc("rst_after0"); cyc("rst_after1"); cyc("rst_after2");

    // Same-cycle visibility of a write (depends on forwarding build option).
    drive(1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 1'b0, "fwd");
`ifdef REG_BANK_BYPASS_EN
    check("fwd.same_cycle", 32'(bus.out_c), 32'h3C);
`else
    check("fwd.same_cycle", 32'(bus.out_c), 32'h00);
`endif
    cyc("fwd_edge");
    check("fwd.after_edge", 32'(bus.out_c), 32'h3C);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            reg_addr_t'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
            "rnd");
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/reg_bank_4x8.md
REG_BANK_4X8 -- requirements
Module: reg_bank_4x8

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each register and of each output.
REQ-002 Parameter: RESET_VAL, default 8'h00, value loaded into every register on reset and on clear.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: wr_en  input  1  write request.
REQ-006 Port: wr_addr  input  2  write target (0=A, 1=B, 2=C, 3=D).
REQ-007 Port: wr_data  input  WIDTH  write value.
REQ-008 Port: inc_en  input  1  increment request.
REQ-009 Port: inc_addr  input  2  increment target.
REQ-010 Port: clr_req  input  1  start a sequential clear of all four registers.
REQ-011 Port: busy  output  1  high while the clear sequence runs.
REQ-012 Port: carry  output  1  registered carry-out of the most recent increment.
REQ-013 Port: out_a, out_b, out_c, out_d  output  WIDTH each  register contents; feed the 4-to-1 8-bit operand mux data inputs.

Function
REQ-014 The block SHALL hold four WIDTH-bit registers, continuously driven on out_a..out_d.
REQ-015 States SHALL be IDLE and CLEAR; the block SHALL leave reset in IDLE.
REQ-016 In IDLE, clr_req=1 SHALL move to CLEAR on the next edge with busy=1 and clear index 0; wr_en/inc_en in that same cycle SHALL be ignored.
REQ-017 In CLEAR, each edge SHALL load RESET_VAL into the register at the clear index and advance the index; after index 3 the block SHALL return to IDLE (busy=1 for exactly 4 cycles).
REQ-018 While busy=1, wr_en, inc_en and clr_req SHALL be ignored.
REQ-019 In IDLE with wr_en=1, the addressed register SHALL take wr_data on the next edge (1-cycle latency to the output).
REQ-020 In IDLE with inc_en=1, the addressed register SHALL take its value +1 modulo 2^WIDTH; carry SHALL take the carry-out (1 only when the value was all-ones).
REQ-021 carry SHALL update only on an executed increment and hold otherwise; clear SHALL NOT change carry.
REQ-022 wr_en and inc_en on the same address SHALL execute the write; the increment SHALL be dropped and carry SHALL hold.
REQ-023 wr_en and inc_en on different addresses SHALL both execute in the same cycle.

Reset
REQ-024 rst_n=0 SHALL immediately force all registers to RESET_VAL, carry=0, busy=0 and state=IDLE, including in the middle of a clear.
REQ-025 All outputs SHALL come directly from flops, except under REQ-027.

Configuration
REQ-026 Macro REG_BANK_BYPASS_EN SHALL select write-through forwarding.
REQ-027 With the macro defined, in IDLE with wr_en=1, the addressed out_x SHALL combinationally show wr_data in the same cycle.
REQ-028 Without the macro, the outputs SHALL show only the register contents (REQ-019 latency).

Structure
REQ-029 Package reg_bank_pkg SHALL hold the WIDTH default, the 2-bit register-address typedef and the IDLE/CLEAR state enum.
REQ-030 The clear sequencer SHALL be the sub-module reg_bank_clear_fsm (outputs: busy, clear index, clear strobe).
REQ-031 The register array, write logic and increment logic SHALL stay in the top module.

Verification
REQ-032 Reset, then write A=00, B=F0, C=0F, D=FF -> outputs 00/F0/0F/FF one cycle after each write; carry=0.
REQ-033 D=FF, inc_en on addr 3 -> out_d=00 and carry=1; inc on addr 3 again -> out_d=01 and carry=0.
REQ-034 wr_en addr 1 data 55 together with inc_en addr 1 -> out_b=55 and carry unchanged; the same stimulus with inc_addr 2 -> out_b=55 and out_c incremented.
REQ-035 clr_req with all registers at AA -> busy=1 for 4 cycles and A..D reach 00 on successive edges; a wr_en issued during busy has no effect.
REQ-036 rst_n low after the second clear cycle -> all outputs 00 and busy=0 immediately; the clear does not resume.
REQ-037 With REG_BANK_BYPASS_EN, wr_en addr 2 data 3C -> out_c=3C in the same cycle; without the macro -> out_c=3C only after the edge.
